// File: rtl/sha256_padder_if.sv
// Byte-in / block-out stream bundle between the host, the SHA-256 padder
// and the compression core. master drives bytes and consumes blocks; slave is the padder.
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length of each message.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  sha256_padder_if.slave bus
);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [5:0]         idx;
  logic [LEN_W-1:0]   bitcnt;
  logic               pad80_done;
  logic               pad_pend;
  logic               last_q;
  logic [511:0]       blk_buf;

  logic               in_fire;
  logic               store_byte;
  logic [6:0]         p_next;
  logic               pad_final;
  logic [63:0]        len64;
  logic [511:0]       pad_block;

  assign in_fire    = bus.in_valid && (state == FILL);
  assign store_byte = in_fire && !(bus.in_last && bus.in_empty);

  assign bus.in_ready  = (state == FILL);
  assign bus.blk_valid = (state == EMIT);
  assign bus.blk_data  = blk_buf;
  assign bus.blk_last  = last_q;

  // Padded image of the current partial block; the length only fits if the
  // marker leaves bytes 56..63 free, otherwise a second block is needed.
  always_comb begin
    len64               = '0;
    len64[LEN_W-1:0]    = bitcnt;
    p_next              = {1'b0, idx} + (pad80_done ? 7'd0 : 7'd1);
    pad_final           = (p_next <= 7'd56);
    pad_block           = blk_buf;
    for (int k = 0; k < 64; k++) begin
      if (!pad80_done && (k == int'(idx))) begin
        pad_block[511-8*k -: 8] = 8'h80;
      end else if (k >= int'(p_next)) begin
        pad_block[511-8*k -: 8] = 8'h00;
      end
    end
    if (pad_final) begin
      pad_block[63:0] = len64;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (in_fire) begin
          if (store_byte && (idx == 6'd63)) begin
            state_nxt = EMIT;
          end else if (bus.in_last) begin
            state_nxt = PAD;
          end
        end
      end
      PAD:  state_nxt = EMIT;
      EMIT: begin
        if (bus.blk_ready) begin
          if (last_q) begin
            state_nxt = FILL;
          end else if (pad_pend) begin
            state_nxt = PAD;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // A full data block whose last byte also ends the message still owes a pad block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      bitcnt     <= '0;
      pad80_done <= 1'b0;
      pad_pend   <= 1'b0;
      last_q     <= 1'b0;
      blk_buf    <= '0;
    end else begin
      case (state)
        FILL: begin
          if (store_byte) begin
            for (int k = 0; k < 64; k++) begin
              if (k == int'(idx)) begin
                blk_buf[511-8*k -: 8] <= bus.in_data;
              end
            end
            idx    <= idx + 6'd1;
            bitcnt <= bitcnt + LEN_W'(8);
            if ((idx == 6'd63) && bus.in_last) begin
              pad_pend <= 1'b1;
            end
          end
        end
        PAD: begin
          blk_buf    <= pad_block;
          pad80_done <= 1'b1;
          last_q     <= pad_final;
          pad_pend   <= !pad_final;
        end
        EMIT: begin
          if (bus.blk_ready) begin
            idx      <= '0;
            blk_buf  <= '0;
            pad_pend <= 1'b0;
            if (last_q) begin
              bitcnt     <= '0;
              pad80_done <= 1'b0;
              last_q     <= 1'b0;
            end
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule
